// File: rtl/phy_rx_lanes.sv
// ---------------------------------------------------------------------------
// phy_rx_lanes
//   Multi-lane serial PHY receiver running entirely on the bit clock.
//   Each lane hunts for the comma byte, aligns to it, and locks after
//   SYNC_COUNT consecutive aligned commas. Once every lane is locked, each
//   lane's bytes are held until all lanes have one. The lane bytes are then
//   striped into DATA_W-bit words. Byte 0 of a word is the MSB byte, and
//   lane k of slot s fills word byte s*LANES+k.
//
// Ports
//   i_clk_32f      in   1       serial bit clock; all logic on the rising edge
//   i_reset        in   1       synchronous, active-high reset
//   i_data_in      in   LANES   one serial bit per lane, MSB of each byte first
//   o_lane_locked  out  LANES   lane i is locked (ACTIVE)
//   o_active_out   out  1       registered AND of all lane locks
//   o_valid_out    out  1       one-cycle strobe: o_data_out holds a new word
//   o_data_out     out  DATA_W  last assembled word, held until the next strobe
//   o_err_out      out  1       one-cycle strobe on overrun or framing error
// ---------------------------------------------------------------------------
module phy_rx_lanes #(
  parameter int         LANES      = 2,
  parameter int         DATA_W     = 32,
  parameter logic [7:0] COMMA      = 8'hBC,
  parameter int         SYNC_COUNT = 4
) (
  input  logic              i_clk_32f,
  input  logic              i_reset,
  input  logic [LANES-1:0]  i_data_in,
  output logic [LANES-1:0]  o_lane_locked,
  output logic              o_active_out,
  output logic              o_valid_out,
  output logic [DATA_W-1:0] o_data_out,
  output logic              o_err_out
);

  localparam int SLOTS = DATA_W / (8 * LANES);
  localparam int IDX_W = (SLOTS > 1) ? $clog2(SLOTS) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(SLOTS - 1);
  localparam logic [3:0]       CCNT_LAST = 4'(SYNC_COUNT - 1);

  typedef enum logic [1:0] {
    ST_HUNT,
    ST_LOCKING,
    ST_ACTIVE
  } lane_state_e;

  // Per-lane results shared with the slot assembler
  logic [7:0]       w_cand [LANES];
  logic [LANES-1:0] w_locked;
  logic [LANES-1:0] w_byte_done;

  // ------------------------------------------------------------------------
  // Per-lane comma hunt, alignment and lock
  // ------------------------------------------------------------------------
  for (genvar g = 0; g < LANES; g++) begin : g_lane
    lane_state_e r_state;
    lane_state_e w_state_nxt;
    logic [6:0]  r_sr;
    logic [2:0]  r_bitcnt;
    logic [3:0]  r_ccnt;
    logic        w_is_comma;
    logic        w_at_byte;

    // Candidate byte includes the bit arriving this cycle
    assign w_cand[g]      = {r_sr, i_data_in[g]};
    assign w_is_comma     = (w_cand[g] == COMMA);
    assign w_at_byte      = (r_bitcnt == 3'd7);
    assign w_locked[g]    = (r_state == ST_ACTIVE);
    assign w_byte_done[g] = w_locked[g] & w_at_byte;

    // NOTE: every signal written in always_comb gets a default first so no
    // path can leave it unassigned (which would infer a latch).
    always_comb begin
      w_state_nxt = r_state;
      case (r_state)
        ST_HUNT: begin
          if (w_is_comma) begin
            w_state_nxt = (SYNC_COUNT == 1) ? ST_ACTIVE : ST_LOCKING;
          end
        end
        ST_LOCKING: begin
          if (w_at_byte) begin
            if (!w_is_comma) begin
              w_state_nxt = ST_HUNT;
            end else if (r_ccnt == CCNT_LAST) begin
              w_state_nxt = ST_ACTIVE;
            end
          end
        end
        default: w_state_nxt = r_state;  // ACTIVE holds until reset
      endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge i_clk_32f) begin
      if (i_reset) begin
        r_state  <= ST_HUNT;
        r_sr     <= '0;
        r_bitcnt <= '0;
        r_ccnt   <= '0;
      end else begin
        r_state <= w_state_nxt;
        r_sr    <= w_cand[g][6:0];
        if (r_state == ST_HUNT) begin
          // The comma seen here defines the byte boundary for this lane
          if (w_is_comma) begin
            r_bitcnt <= '0;
            r_ccnt   <= 4'd1;
          end
        end else begin
          r_bitcnt <= r_bitcnt + 3'd1;
          if ((r_state == ST_LOCKING) && w_at_byte) begin
            r_ccnt <= w_is_comma ? (r_ccnt + 4'd1) : 4'd0;
          end
        end
      end
    end
  end

  // ------------------------------------------------------------------------
  // Hold stage and slot assembler
  // ------------------------------------------------------------------------
  logic              r_active;
  logic              r_valid;
  logic              r_err;
  logic [DATA_W-1:0] r_data;
  logic [DATA_W-1:0] r_word;
  logic [IDX_W-1:0]  r_idx;
  logic [7:0]        r_hold [LANES];
  logic [LANES-1:0]  r_hold_v;

  logic              w_slot_take;
  logic              w_all_comma;
  logic              w_no_comma;
  logic              w_slot_err;
  logic              w_overrun;
  logic [LANES-1:0]  w_capture;
  logic [DATA_W-1:0] w_word_nxt;

  always_comb begin
    w_slot_take = r_active & (&r_hold_v);
    w_all_comma = 1'b1;
    w_no_comma  = 1'b1;
    w_word_nxt  = r_word;
    for (int k = 0; k < LANES; k++) begin
      if (r_hold[k] == COMMA) begin
        w_no_comma = 1'b0;
      end else begin
        w_all_comma = 1'b0;
      end
    end
    // Drop the slot's bytes into the word at the current slot index
    for (int s = 0; s < SLOTS; s++) begin
      if (r_idx == IDX_W'(s)) begin
        for (int k = 0; k < LANES; k++) begin
          w_word_nxt[DATA_W-1-8*(s*LANES+k) -: 8] = r_hold[k];
        end
      end
    end
    // Idle slot while a word is half built, or a comma/data mix
    w_slot_err = w_slot_take &
                 ((w_all_comma & (r_idx != '0)) | (~w_all_comma & ~w_no_comma));
    // Bytes finished before all lanes are locked are simply dropped
    w_capture  = w_byte_done & {LANES{r_active}};
    // A byte landing on a hold that is consumed this same cycle is not lost
    w_overrun  = (|(w_capture & r_hold_v)) & ~w_slot_take;
  end

  always_ff @(posedge i_clk_32f) begin
    if (i_reset) begin
      r_active <= 1'b0;
      r_valid  <= 1'b0;
      r_err    <= 1'b0;
      r_data   <= '0;
      r_word   <= '0;
      r_idx    <= '0;
      r_hold_v <= '0;
      // NOTE: the hold bytes are tiny, so they are reset with their valid
      // flags; nothing downstream ever sees stale or X data from them.
      for (int k = 0; k < LANES; k++) begin
        r_hold[k] <= '0;
      end
    end else begin
      r_active <= &w_locked;
      r_valid  <= 1'b0;
      r_err    <= w_overrun | w_slot_err;
      for (int k = 0; k < LANES; k++) begin
        r_hold_v[k] <= w_capture[k] | (r_hold_v[k] & ~w_slot_take);
        if (w_capture[k]) begin
          r_hold[k] <= w_cand[k];
        end
      end
      if (w_slot_take) begin
        if (w_no_comma) begin
          r_word <= w_word_nxt;
          if (r_idx == IDX_LAST) begin
            r_data  <= w_word_nxt;
            r_valid <= 1'b1;
            r_idx   <= '0;
          end else begin
            r_idx <= r_idx + 1'b1;
          end
        end else begin
          // Idle or mixed slot: restart word assembly
          r_idx <= '0;
        end
      end
    end
  end

  assign o_lane_locked = w_locked;
  assign o_active_out  = r_active;
  assign o_valid_out   = r_valid;
  assign o_data_out    = r_data;
  assign o_err_out     = r_err;

endmodule
